// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - MEM-stage data-memory responder; optional wait-state FSM under DM_WAIT_EN
module dm_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_DM_read,
    input  logic        mem_DM_write,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_sw_o,
    output logic [31:0] dm_rdata,
    output logic        dm_rvalid,
    output logic        dm_stall,
    output logic        dm_addr_err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rdata;
    logic          r_rvalid;
    logic          r_addr_err;

    logic          w_req;
    logic [AW-1:0] w_in_idx;
    logic [31:0]   w_word;
    logic          w_in_err;
    logic          w_in_rd;
    logic          w_accept;
    logic          w_we;

    assign w_req    = mem_DM_read | mem_DM_write;
    assign w_in_idx = mem_alu_result[2 +: AW];
    assign w_word   = {2'b00, mem_alu_result[31:2]};
    assign w_in_err = (mem_alu_result[1:0] != 2'b00) | (w_word >= 32'(DEPTH));
    // Both strobes high resolves to a write, so a read is only a pure read.
    assign w_in_rd  = mem_DM_read & ~mem_DM_write;
    assign w_we     = w_accept & mem_DM_write & ~w_in_err;

    // Array has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_in_idx] <= mem_sw_o;
        end
    end

`ifdef DM_WAIT_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_next;
    logic [AW-1:0] r_idx;
    logic          r_rd;
    logic          r_err;
    logic [AW-1:0] w_sel_idx;
    logic          w_sel_rd;
    logic          w_sel_err;
    logic          w_resp_en;

    assign w_accept = (r_state == S_IDLE) & w_req & ~rst;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES > 0) begin
                        w_next     = S_WAIT;
                        w_cnt_next = 4'(WAIT_CYCLES - 1);
                    end else begin
                        w_next = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx <= w_in_idx;
            r_rd  <= w_in_rd;
            r_err <= w_in_err;
        end
    end

    // With zero wait states RESP follows IDLE directly, before the latches fill.
    assign w_sel_idx = (r_state == S_IDLE) ? w_in_idx : r_idx;
    assign w_sel_rd  = (r_state == S_IDLE) ? w_in_rd  : r_rd;
    assign w_sel_err = (r_state == S_IDLE) ? w_in_err : r_err;
    assign w_resp_en = (w_next == S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata    <= 32'd0;
            r_rvalid   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rvalid   <= w_resp_en & w_sel_rd;
            r_addr_err <= w_resp_en & w_sel_err;
            if (w_resp_en & w_sel_rd) begin
                r_rdata <= w_sel_err ? 32'd0 : r_mem[w_sel_idx];
            end
        end
    end

    assign dm_stall = ~rst & (((r_state == S_IDLE) & w_req) | (r_state == S_WAIT));
`else
    assign w_accept = w_req & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata    <= 32'd0;
            r_rvalid   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rvalid   <= w_accept & w_in_rd;
            r_addr_err <= w_accept & w_in_err;
            if (w_accept & w_in_rd) begin
                r_rdata <= w_in_err ? 32'd0 : r_mem[w_in_idx];
            end
        end
    end

    assign dm_stall = 1'b0;
`endif

    assign dm_rdata    = r_rdata;
    assign dm_rvalid   = r_rvalid;
    assign dm_addr_err = r_addr_err;

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - scoreboard bench for dm_responder (either DM_WAIT_EN build)
module tb_dm_responder;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_DM_read = 1'b0;
    logic        mem_DM_write = 1'b0;
    logic [31:0] mem_alu_result = 32'd0;
    logic [31:0] mem_sw_o = 32'd0;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic        dm_stall;
    logic        dm_addr_err;

    dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_DM_read    (mem_DM_read),
        .mem_DM_write   (mem_DM_write),
        .mem_alu_result (mem_alu_result),
        .mem_sw_o       (mem_sw_o),
        .dm_rdata       (dm_rdata),
        .dm_rvalid      (dm_rvalid),
        .dm_stall       (dm_stall),
        .dm_addr_err    (dm_addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(negedge clk) begin
        if (dm_rvalid === 1'b1 || dm_addr_err === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected rvalid=%b addr_err=%b rdata=%h required no response",
                         dm_rvalid, dm_addr_err, dm_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (dm_rvalid !== e.rv || dm_addr_err !== e.err || (e.rv && dm_rdata !== e.data)) begin
                    n_bad++;
                    $display("FAIL sb_resp got rv=%b err=%b data=%h required rv=%b err=%b data=%h",
                             dm_rvalid, dm_addr_err, dm_rdata, e.rv, e.err, e.data);
                end
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic        err;
        logic        is_rd;
        logic [31:0] word;
        int          idx;
        exp_t        e;
        word  = {2'b00, addr[31:2]};
        err   = (addr[1:0] != 2'b00) || (word >= 32'(DEPTH));
        is_rd = rd & ~wr;
        idx   = int'(addr[9:2]);
        if (is_rd || err) begin
            e.rv   = is_rd;
            e.err  = err;
            e.data = err ? 32'd0 : model[idx];
            sb.push_back(e);
        end
        if (wr && !err) model[idx] = wdata;
        mem_DM_read    = rd;
        mem_DM_write   = wr;
        mem_alu_result = addr;
        mem_sw_o       = wdata;
`ifdef DM_WAIT_EN
        for (int c = 0; c <= W; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dm_stall !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_wait cyc=%0d got %b required 1", c, dm_stall);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if (dm_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_resp got %b required 0", dm_stall);
        end
        @(posedge clk); #1;
`else
        @(negedge clk);
        n_cmp++;
        if (dm_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_nowait got %b required 0", dm_stall);
        end
        @(posedge clk); #1;
`endif
    endtask

    task automatic idle(input int n);
        mem_DM_read  = 1'b0;
        mem_DM_write = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            mem_DM_read    = 1'($urandom);
            mem_DM_write   = 1'b0;
            mem_alu_result = $urandom;
            mem_sw_o       = $urandom;
            @(negedge clk);
            n_cmp++;
            if (dm_rdata !== 32'd0 || dm_rvalid !== 1'b0 || dm_addr_err !== 1'b0 || dm_stall !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outs got rdata=%h rv=%b err=%b stall=%b required all 0",
                         dm_rdata, dm_rvalid, dm_addr_err, dm_stall);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_write_read();
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        access(1'b0, 1'b1, 32'h3FC, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'h3FC, 32'h0);
        idle(2);
    endtask

    task automatic test_addr_err();
        access(1'b0, 1'b1, 32'h0, 32'h0000A5A5);
        access(1'b1, 1'b0, 32'h13, 32'h0);
        access(1'b0, 1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF);
        access(1'b1, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b0, 32'h8000_0000, 32'h0);
        idle(2);
    endtask

    task automatic test_both_strobes();
        access(1'b1, 1'b1, 32'h20, 32'h5);
        idle(1);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        idle(2);
    endtask

    task automatic test_reset_mid();
        mem_DM_read    = 1'b1;
        mem_DM_write   = 1'b0;
        mem_alu_result = 32'h10;
`ifdef DM_WAIT_EN
        @(posedge clk); #1;
`endif
        rst          = 1'b1;
        mem_DM_read  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dm_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_stall got %b required 0", dm_stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dm_rvalid !== 1'b0 || dm_stall !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mid_drop cyc=%0d got rv=%b stall=%b required 0 0", c, dm_rvalid, dm_stall);
            end
            @(posedge clk); #1;
        end
        access(1'b1, 1'b0, 32'h10, 32'h0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) access(1'b0, 1'b1, 32'(4 * i), 32'(i + 1));
        for (int i = 0; i < 3; i++) access(1'b1, 1'b0, 32'(4 * i), 32'h0);
        for (int i = 0; i < 4; i++) access(1'b0, 1'b1, 32'h40 + 32'(4 * i), $urandom);
        for (int i = 3; i >= 0; i--) access(1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h0);
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_addr_err();
        test_both_strobes();
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain got %0d outstanding required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
